// File: rtl/bounded_response_monitor_pkg.sv
// ----------------------------------------------------------------------------
// bounded_response_monitor_pkg
// Shared definitions for the bounded response monitor:
//   match_mode_e   - response matching policy (MATCH_ONE=0, MATCH_ALL=1)
//   MAX_DLY_LIMIT  - largest legal response window (ages 1..32)
//   MAX_CH         - largest legal channel count
//   count_ones     - population count used to total error pulses per cycle
// ----------------------------------------------------------------------------
package bounded_response_monitor_pkg;

    typedef enum logic {
        MATCH_ONE = 1'b0,
        MATCH_ALL = 1'b1
    } match_mode_e;

    localparam int MAX_DLY_LIMIT = 32;
    localparam int MAX_CH        = 16;

    // Result is 6 bits so two counts of up to 16 can be summed without overflow.
    function automatic logic [5:0] count_ones(input logic [MAX_CH-1:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < MAX_CH; i++) begin
            n = n + {5'b0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/bounded_response_monitor_if.sv
// ----------------------------------------------------------------------------
// bounded_response_monitor_if
// Bundles the per-channel request/response pulses and the monitor's status
// outputs.
//   req, rsp      - per-channel pulses driven by the observed system (master)
//   err_timeout   - per-channel pulse, a request expired unanswered
//   err_spurious  - per-channel pulse, a response had no eligible request
//   busy          - per-channel, at least one request pending
//   fail          - sticky error flag
//   err_count     - saturating error total
// Modports: master drives req/rsp, slave (the monitor) drives the status.
// ----------------------------------------------------------------------------
interface bounded_response_monitor_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8
);
    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] rsp;
    logic [NUM_CH-1:0] err_timeout;
    logic [NUM_CH-1:0] err_spurious;
    logic [NUM_CH-1:0] busy;
    logic              fail;
    logic [CNT_W-1:0]  err_count;

    modport master (
        output req,
        output rsp,
        input  err_timeout,
        input  err_spurious,
        input  busy,
        input  fail,
        input  err_count
    );

    modport slave (
        input  req,
        input  rsp,
        output err_timeout,
        output err_spurious,
        output busy,
        output fail,
        output err_count
    );
endinterface

// File: rtl/bounded_response_monitor_channel.sv
// ----------------------------------------------------------------------------
// brm_channel
// Tracks outstanding requests of one channel as a vector of ages.
// Bit i of pend means "a request is i+1 cycles old in the current cycle".
// Ports:
//   clock, reset   - clock and asynchronous active-high reset
//   req, rsp       - request / response pulses of this channel
//   err_timeout    - registered pulse, a request aged out unanswered
//   err_spurious   - registered pulse, a response found nothing eligible
//   busy           - registered, some request is pending
//   timeout_evt    - combinational timeout event (next-cycle err_timeout)
//   spurious_evt   - combinational spurious event (next-cycle err_spurious)
// The *_evt outputs let the top update fail/err_count in the same cycle the
// registered pulses appear.
// ----------------------------------------------------------------------------
module brm_channel
    import bounded_response_monitor_pkg::*;
#(
    parameter int          MIN_DLY        = 1,
    parameter int          MAX_DLY        = 4,
    parameter match_mode_e MODE           = MATCH_ONE,
    parameter bit          CHECK_SPURIOUS = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic req,
    input  logic rsp,
    output logic err_timeout,
    output logic err_spurious,
    output logic busy,
    output logic timeout_evt,
    output logic spurious_evt
);

    logic [MAX_DLY-1:0] pend;
    logic [MAX_DLY-1:0] elig_mask;
    logic [MAX_DLY-1:0] elig;
    logic [MAX_DLY-1:0] clr;
    logic [MAX_DLY-1:0] remain;
    logic [MAX_DLY-1:0] pend_next;

    // Ages MIN_DLY..MAX_DLY may be answered.
    always_comb begin
        elig_mask = '0;
        for (int i = 0; i < MAX_DLY; i++) begin
            if (i + 1 >= MIN_DLY) begin
                elig_mask[i] = 1'b1;
            end
        end
    end

    assign elig = pend & elig_mask;

    // Oldest request sits at the highest index, so the last hit in the
    // ascending scan is the one a single response consumes.
    always_comb begin
        clr = '0;
        if (rsp) begin
            if (MODE == MATCH_ALL) begin
                clr = elig;
            end else begin
                for (int i = 0; i < MAX_DLY; i++) begin
                    if (elig[i]) begin
                        clr    = '0;
                        clr[i] = 1'b1;
                    end
                end
            end
        end
    end

    assign remain       = pend & ~clr;
    assign timeout_evt  = remain[MAX_DLY-1];
    assign spurious_evt = CHECK_SPURIOUS & rsp & ~(|elig);

    // The new request enters at age 1 after matching, so a response in the
    // same cycle can never consume it.
    always_comb begin
        pend_next    = '0;
        pend_next[0] = req;
        for (int i = 1; i < MAX_DLY; i++) begin
            pend_next[i] = remain[i-1];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pend         <= '0;
            err_timeout  <= 1'b0;
            err_spurious <= 1'b0;
            busy         <= 1'b0;
        end else begin
            pend         <= pend_next;
            err_timeout  <= timeout_evt;
            err_spurious <= spurious_evt;
            busy         <= |pend_next;
        end
    end

endmodule

// File: rtl/bounded_response_monitor.sv
// ----------------------------------------------------------------------------
// bounded_response_monitor
// Checks that every request on each of NUM_CH channels is answered between
// MIN_DLY and MAX_DLY cycles later. Per-channel tracking lives in brm_channel;
// this level aggregates the error events into a sticky fail flag and a
// saturating error counter.
// Ports:
//   clock  - sole clock, rising edge
//   reset  - asynchronous, active-high reset
//   mon    - bounded_response_monitor_if.slave: req/rsp in,
//            err_timeout/err_spurious/busy/fail/err_count out
// ----------------------------------------------------------------------------
module bounded_response_monitor
    import bounded_response_monitor_pkg::*;
#(
    parameter int          NUM_CH         = 4,
    parameter int          MIN_DLY        = 1,
    parameter int          MAX_DLY        = 4,
    parameter match_mode_e MODE           = MATCH_ONE,
    parameter int          CHECK_SPURIOUS = 1,
    parameter int          CNT_W          = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    bounded_response_monitor_if.slave   mon
);

    if (NUM_CH < 1 || NUM_CH > MAX_CH) begin : g_bad_num_ch
        $error("bounded_response_monitor: NUM_CH must be 1..16");
    end
    if (MIN_DLY < 1 || MIN_DLY > MAX_DLY) begin : g_bad_min_dly
        $error("bounded_response_monitor: MIN_DLY must be 1..MAX_DLY");
    end
    if (MAX_DLY > MAX_DLY_LIMIT) begin : g_bad_max_dly
        $error("bounded_response_monitor: MAX_DLY must not exceed 32");
    end
    if (CHECK_SPURIOUS != 0 && CHECK_SPURIOUS != 1) begin : g_bad_check
        $error("bounded_response_monitor: CHECK_SPURIOUS must be 0 or 1");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("bounded_response_monitor: CNT_W must be at least 1");
    end

    localparam int SUM_W = CNT_W + 6;

    logic [NUM_CH-1:0] tmo_q;
    logic [NUM_CH-1:0] spur_q;
    logic [NUM_CH-1:0] busy_q;
    logic [NUM_CH-1:0] tmo_evt;
    logic [NUM_CH-1:0] spur_evt;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        brm_channel #(
            .MIN_DLY        (MIN_DLY),
            .MAX_DLY        (MAX_DLY),
            .MODE           (MODE),
            .CHECK_SPURIOUS (CHECK_SPURIOUS != 0)
        ) u_ch (
            .clock        (clock),
            .reset        (reset),
            .req          (mon.req[g]),
            .rsp          (mon.rsp[g]),
            .err_timeout  (tmo_q[g]),
            .err_spurious (spur_q[g]),
            .busy         (busy_q[g]),
            .timeout_evt  (tmo_evt[g]),
            .spurious_evt (spur_evt[g])
        );
    end

    logic [MAX_CH-1:0] tmo_pad;
    logic [MAX_CH-1:0] spur_pad;
    logic [5:0]        evt_num;
    logic [SUM_W-1:0]  cnt_sum;
    logic [CNT_W-1:0]  cnt_next;
    logic [CNT_W-1:0]  cnt_q;
    logic              fail_q;

    always_comb begin
        tmo_pad              = '0;
        spur_pad             = '0;
        tmo_pad[NUM_CH-1:0]  = tmo_evt;
        spur_pad[NUM_CH-1:0] = spur_evt;
    end

    // A timeout and a spurious response on the same channel count as two.
    assign evt_num = count_ones(tmo_pad) + count_ones(spur_pad);
    assign cnt_sum = {6'b0, cnt_q} + {{CNT_W{1'b0}}, evt_num};

    always_comb begin
        if (cnt_sum[SUM_W-1:CNT_W] != '0) begin
            cnt_next = '1;
        end else begin
            cnt_next = cnt_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            fail_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_next;
            fail_q <= fail_q | (|tmo_evt) | (|spur_evt);
        end
    end

    assign mon.err_timeout  = tmo_q;
    assign mon.err_spurious = spur_q;
    assign mon.busy         = busy_q;
    assign mon.fail         = fail_q;
    assign mon.err_count    = cnt_q;

endmodule

// File: tb/tb_bounded_response_monitor.sv
module tb_bounded_response_monitor;
    import bounded_response_monitor_pkg::*;

    localparam int NI = 5;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic [3:0] req_a [NI];
    logic [3:0] rsp_a [NI];

    // dut0 defaults, dut1 MIN_DLY=2, dut2 MATCH_ALL, dut3 CNT_W=2,
    // dut4 MIN_DLY=MAX_DLY=1 MATCH_ALL
    bounded_response_monitor_if #(.NUM_CH(4), .CNT_W(8)) if0 ();
    bounded_response_monitor_if #(.NUM_CH(4), .CNT_W(8)) if1 ();
    bounded_response_monitor_if #(.NUM_CH(4), .CNT_W(8)) if2 ();
    bounded_response_monitor_if #(.NUM_CH(4), .CNT_W(2)) if3 ();
    bounded_response_monitor_if #(.NUM_CH(4), .CNT_W(8)) if4 ();

    assign if0.req = req_a[0]; assign if0.rsp = rsp_a[0];
    assign if1.req = req_a[1]; assign if1.rsp = rsp_a[1];
    assign if2.req = req_a[2]; assign if2.rsp = rsp_a[2];
    assign if3.req = req_a[3]; assign if3.rsp = rsp_a[3];
    assign if4.req = req_a[4]; assign if4.rsp = rsp_a[4];

    bounded_response_monitor #(.NUM_CH(4), .MIN_DLY(1), .MAX_DLY(4), .MODE(MATCH_ONE),
        .CHECK_SPURIOUS(1), .CNT_W(8)) u0 (.clock(clock), .reset(reset), .mon(if0));
    bounded_response_monitor #(.NUM_CH(4), .MIN_DLY(2), .MAX_DLY(4), .MODE(MATCH_ONE),
        .CHECK_SPURIOUS(1), .CNT_W(8)) u1 (.clock(clock), .reset(reset), .mon(if1));
    bounded_response_monitor #(.NUM_CH(4), .MIN_DLY(1), .MAX_DLY(4), .MODE(MATCH_ALL),
        .CHECK_SPURIOUS(1), .CNT_W(8)) u2 (.clock(clock), .reset(reset), .mon(if2));
    bounded_response_monitor #(.NUM_CH(4), .MIN_DLY(1), .MAX_DLY(4), .MODE(MATCH_ONE),
        .CHECK_SPURIOUS(1), .CNT_W(2)) u3 (.clock(clock), .reset(reset), .mon(if3));
    bounded_response_monitor #(.NUM_CH(4), .MIN_DLY(1), .MAX_DLY(1), .MODE(MATCH_ALL),
        .CHECK_SPURIOUS(1), .CNT_W(8)) u4 (.clock(clock), .reset(reset), .mon(if4));

    int mn   [NI] = '{1, 2, 1, 1, 1};
    int mx   [NI] = '{4, 4, 4, 4, 1};
    int one  [NI] = '{1, 1, 0, 1, 0};
    int cmax [NI] = '{255, 255, 255, 3, 255};

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input int i, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d cycle %0d: actual %0h required %0h", nm, i, cyc, act, exp);
        end
    endtask

    // Reference model: each channel keeps a list of issue cycles, oldest first.
    int         iss [NI][4][8];
    int         nq  [NI][4];
    logic [3:0] e_tmo  [NI];
    logic [3:0] e_spur [NI];
    logic [3:0] e_busy [NI];
    logic       e_fail [NI];
    int         e_cnt  [NI];

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            for (int ch = 0; ch < 4; ch++) nq[i][ch] = 0;
            e_tmo[i] = '0; e_spur[i] = '0; e_busy[i] = '0;
            e_fail[i] = 1'b0; e_cnt[i] = 0;
        end
    endtask

    task automatic model_step(input int i, input int cur);
        int w, age, nerr;
        bit hit, tmo, spur;
        nerr = 0;
        for (int ch = 0; ch < 4; ch++) begin
            tmo = 0; spur = 0;
            if (rsp_a[i][ch]) begin
                hit = 0; w = 0;
                for (int k = 0; k < nq[i][ch]; k++) begin
                    age = cur - iss[i][ch][k];
                    if (age >= mn[i] && age <= mx[i] && !(one[i] != 0 && hit)) hit = 1;
                    else begin iss[i][ch][w] = iss[i][ch][k]; w++; end
                end
                nq[i][ch] = w;
                spur = !hit;
            end
            w = 0;
            for (int k = 0; k < nq[i][ch]; k++) begin
                age = cur - iss[i][ch][k];
                if (age >= mx[i]) tmo = 1;
                else begin iss[i][ch][w] = iss[i][ch][k]; w++; end
            end
            nq[i][ch] = w;
            if (req_a[i][ch]) begin
                iss[i][ch][nq[i][ch]] = cur;
                nq[i][ch]++;
            end
            e_tmo[i][ch]  = tmo;
            e_spur[i][ch] = spur;
            e_busy[i][ch] = (nq[i][ch] != 0);
            nerr += int'(tmo) + int'(spur);
        end
        e_cnt[i] = (e_cnt[i] + nerr > cmax[i]) ? cmax[i] : e_cnt[i] + nerr;
        if (nerr != 0) e_fail[i] = 1'b1;
    endtask

    always @(posedge clock or posedge reset) begin
        if (reset) model_reset();
        else for (int i = 0; i < NI; i++) model_step(i, cyc);
    end

    task automatic cmp(input int i, input logic [3:0] t, input logic [3:0] s,
                       input logic [3:0] b, input logic f, input logic [31:0] c);
        check("err_timeout", i, t, e_tmo[i]);
        check("err_spurious", i, s, e_spur[i]);
        check("busy", i, b, e_busy[i]);
        check("fail", i, f, e_fail[i]);
        check("err_count", i, c, e_cnt[i]);
    endtask

    always @(negedge clock) begin
        cmp(0, if0.err_timeout, if0.err_spurious, if0.busy, if0.fail, if0.err_count);
        cmp(1, if1.err_timeout, if1.err_spurious, if1.busy, if1.fail, if1.err_count);
        cmp(2, if2.err_timeout, if2.err_spurious, if2.busy, if2.fail, if2.err_count);
        cmp(3, if3.err_timeout, if3.err_spurious, if3.busy, if3.fail, if3.err_count);
        cmp(4, if4.err_timeout, if4.err_spurious, if4.busy, if4.fail, if4.err_count);
    end

    task automatic clear_inputs();
        for (int i = 0; i < NI; i++) begin
            req_a[i] = '0;
            rsp_a[i] = '0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int dens;
        clear_inputs();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // Directed window: literal expectations for the key scenarios.
        while (cyc < 25) begin
            @(posedge clock); #1;
            case (cyc)
                11: begin
                    check("busy0_c11", 0, if0.busy[0], 1);
                    check("spur2_c11", 4, if4.err_spurious[2], 1);
                end
                12: begin
                    check("spur2_c12", 1, if1.err_spurious[2], 1);
                    check("tmo1_c12", 4, if4.err_timeout[1], 1);
                    check("cnt_c12", 4, if4.err_count, 2);
                end
                13: check("busy0_c13", 0, if0.busy[0], 1);
                14: begin
                    check("busy0_c14", 0, if0.busy[0], 0);
                    check("cnt_c14", 0, if0.err_count, 0);
                    check("busy2_c14", 1, if1.busy[2], 1);
                end
                15: begin
                    check("tmo1_c15", 0, if0.err_timeout[1], 1);
                    check("fail_c15", 0, if0.fail, 1);
                    check("cnt_c15", 0, if0.err_count, 1);
                    check("tmo2_c15", 1, if1.err_timeout[2], 1);
                    check("cnt_c15", 1, if1.err_count, 2);
                end
                16: begin
                    check("tmo1_c16", 0, if0.err_timeout[1], 0);
                    check("tmo3_c16", 0, if0.err_timeout[3], 1);
                    check("cnt_c16", 0, if0.err_count, 2);
                    check("cnt_c16", 3, if3.err_count, 2);
                end
                17: check("cnt_c17", 3, if3.err_count, 3);
                19: check("cnt_c19", 3, if3.err_count, 3);
                20: begin
                    check("fail_c20", 2, if2.fail, 0);
                    check("cnt_c20", 2, if2.err_count, 0);
                end
                default: ;
            endcase
            clear_inputs();
            case (cyc)
                10: begin
                    req_a[0] = 4'b1011; req_a[1] = 4'b0100; req_a[2] = 4'b1000;
                    req_a[3] = 4'b0001; req_a[4] = 4'b0011; rsp_a[4] = 4'b0100;
                end
                11: begin
                    req_a[0] = 4'b1000; rsp_a[1] = 4'b0100; req_a[2] = 4'b1000;
                    req_a[3] = 4'b0001; rsp_a[4] = 4'b0001;
                end
                12: begin
                    rsp_a[0] = 4'b1000; rsp_a[2] = 4'b1000; req_a[3] = 4'b0001;
                end
                13: begin
                    rsp_a[0] = 4'b0001; req_a[3] = 4'b0001;
                end
                14: req_a[3] = 4'b0001;
                default: ;
            endcase
        end

        // Randomized traffic with a density that steps up over time.
        for (int k = 0; k < 1500; k++) begin
            @(posedge clock); #1;
            dens = 10 + (k / 300) * 15;
            for (int i = 0; i < NI; i++) begin
                for (int ch = 0; ch < 4; ch++) begin
                    req_a[i][ch] = ($urandom_range(0, 99) < dens);
                    rsp_a[i][ch] = ($urandom_range(0, 99) < dens);
                end
            end
        end

        // Drain, then reset with three requests in flight on dut0 channel 0.
        clear_inputs();
        repeat (8) @(posedge clock);
        #1;
        for (int k = 0; k < 3; k++) begin
            clear_inputs();
            req_a[0][0] = 1'b1;
            @(posedge clock); #1;
        end
        clear_inputs();
        check("busy0_prerst", 0, if0.busy[0], 1);
        reset = 1'b1;
        for (int i = 0; i < NI; i++) req_a[i] = 4'hF;
        #1;
        check("busy_rst", 0, if0.busy, 0);
        check("fail_rst", 0, if0.fail, 0);
        check("cnt_rst", 0, if0.err_count, 0);
        check("cnt_rst", 3, if3.err_count, 0);
        repeat (2) @(posedge clock);
        #1;
        clear_inputs();
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clock); #1;
            check("tmo_after_rst", 0, if0.err_timeout, 0);
            check("busy_after_rst", 0, if0.busy, 0);
            check("fail_after_rst", 0, if0.fail, 0);
        end

        repeat (2) @(posedge clock);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
